// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg
// Shared definitions for the memory responder slice.
//   state_t          responder FSM encoding (IDLE, WAIT, RESP)
//   DEF_*            default width/depth/latency values used by mem_responder
//   WAIT_W           width of the wait-state counter (supports 0..15 waits)
package mem_resp_pkg;

  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_DEPTH       = 256;
  localparam int DEF_WAIT_CYCLES = 2;
  localparam int WAIT_W          = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_array.sv
// mem_array
// Word storage behind the responder: synchronous write, combinational read.
// The array is deliberately not reset so it behaves like a real RAM.
// Ports:
//   clk    in   1        rising-edge clock for writes
//   we     in   1        write enable
//   waddr  in   AW       write word index
//   wdata  in   DATA_W   write data
//   raddr  in   AW       read word index
//   rdata  out  DATA_W   read data (combinational)
module mem_array #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Single write port; the responder only asserts we on the edge that
  // leaves its response cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// mem_responder
// Memory-side responder for the multicycle controller. Accepts one word
// request at a time in IDLE, waits WAIT_CYCLES clocks, then produces a
// one-cycle response. Stores commit on the edge leaving the response cycle;
// out-of-range addresses report rsp_err and never touch the array.
// Ports:
//   clk        in   1        system clock, rising edge
//   rst        in   1        asynchronous, active-low reset
//   req_valid  in   1        request present
//   req_write  in   1        1 = store, 0 = read
//   req_addr   in   ADDR_W   word address
//   req_wdata  in   DATA_W   store data
//   req_ready  out  1        high exactly while IDLE
//   rsp_valid  out  1        one-cycle response strobe
//   rsp_rdata  out  DATA_W   read data; 0 for stores and errors
//   rsp_err    out  1        address >= DEPTH (valid with rsp_valid)
//   busy       out  1        high from accept through the response cycle
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES > 0) ? WAIT_W'(WAIT_CYCLES - 1) : '0;

  state_t            state, state_next;
  logic [WAIT_W-1:0] cnt, cnt_next;
  logic              load_rsp;

  logic              cap_write;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;

  logic              src_write;
  logic [ADDR_W-1:0] src_addr;
  logic              src_in_range;
  logic              cap_in_range;
  logic [DATA_W-1:0] rd_data;
  logic              mem_we;

  // With zero wait states the response is loaded on the accept edge itself,
  // before the capture registers hold the request, so the lookup path takes
  // the live request inputs while IDLE and the captured copy otherwise.
  assign src_write    = (state == IDLE) ? req_write : cap_write;
  assign src_addr     = (state == IDLE) ? req_addr  : cap_addr;
  assign src_in_range = ({1'b0, src_addr} < DEPTH_LIM);
  assign cap_in_range = ({1'b0, cap_addr} < DEPTH_LIM);

  // Stores are only committed as the FSM leaves RESP, so a reset anywhere
  // earlier in the transaction drops the store.
  assign mem_we = (state == RESP) && cap_write && cap_in_range;

  mem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (cap_addr[AW-1:0]),
    .wdata (cap_wdata),
    .raddr (src_addr[AW-1:0]),
    .rdata (rd_data)
  );

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  // State and wait counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic. The counter is loaded with WAIT_CYCLES-1 on accept so
  // that reaching zero marks the last wait cycle; load_rsp flags the edge
  // that enters RESP so the response registers update on that same edge.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load_rsp   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
            load_rsp   = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_next = RESP;
          load_rsp   = 1'b1;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request capture: only taken on accept, so anything presented while busy
  // is ignored and must be held or re-presented by the requester.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else if ((state == IDLE) && req_valid) begin
      cap_write <= req_write;
      cap_addr  <= req_addr;
      cap_wdata <= req_wdata;
    end
  end

  // Response registers. Read data is held until the next response; the
  // error flag is cleared as RESP exits so it reads 0 in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (load_rsp) begin
      rsp_err   <= !src_in_range;
      rsp_rdata <= (src_write || !src_in_range) ? '0 : rd_data;
    end else if (state == RESP) begin
      rsp_err <= 1'b0;
    end
  end

endmodule
